// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for two req/ack clients sharing a single-port RAM.
// Latency: 3 cycles per transaction (IDLE, ACCESS, DONE); ack in cycle k+2 after req sampled at edge k.
// Backpressure: a losing request stays pending until the next IDLE; inputs are ignored while busy.
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef RAM_ARB_STATS_EN
    output logic [CNT_W-1:0]  a_grants,
    output logic [CNT_W-1:0]  b_grants,
`endif
    output logic              busy,
    output logic              grant_b
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;
    logic                win_b_q;
    logic                last_b_q;
    logic                a_ack_q;
    logic                b_ack_q;
    logic                grant_b_d;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_b_d = b_req;
        if (a_req && b_req) begin
            grant_b_d = ~last_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            win_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        win_b_q <= grant_b_d;
                        we_q    <= grant_b_d ? b_we    : a_we;
                        addr_q  <= grant_b_d ? b_addr  : a_addr;
                        wdata_q <= grant_b_d ? b_wdata : a_wdata;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (win_b_q) begin
                            b_rdata_q <= mem_rdata;
                        end else begin
                            a_rdata_q <= mem_rdata;
                        end
                    end
                    a_ack_q <= ~win_b_q;
                    b_ack_q <= win_b_q;
                    state_q <= DONE;
                end
                DONE: begin
                    last_b_q <= win_b_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [CNT_W-1:0] a_cnt_q;
    logic [CNT_W-1:0] b_cnt_q;

    // Saturating: the counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else if (state_q == DONE) begin
            if (!win_b_q && (a_cnt_q != {CNT_W{1'b1}})) begin
                a_cnt_q <= a_cnt_q + CNT_W'(1);
            end
            if (win_b_q && (b_cnt_q != {CNT_W{1'b1}})) begin
                b_cnt_q <= b_cnt_q + CNT_W'(1);
            end
        end
    end

    assign a_grants = a_cnt_q;
    assign b_grants = b_cnt_q;
`endif

    // A reset landing in ACCESS must not let the pending write through.
    assign mem_wr_en = ~((state_q == ACCESS) & we_q & ~reset);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != IDLE);
    assign grant_b   = win_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 1024x8 RAM; grant counter checks need RAM_ARB_STATS_EN.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [9:0] a_addr, b_addr, mem_addr;
    logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic       a_ack, b_ack, mem_wr_en, busy, grant_b;
`ifdef RAM_ARB_STATS_EN
    logic [1:0] a_grants, b_grants;
`endif

    typedef struct {
        logic       who_b;
        logic       rd;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_wr = 0;
    int         nb_ack = 0;
    logic [7:0] ram [1024];
    bit         preloaded = 1'b0;

    ram_arbiter #(.ADDR_W(10), .DATA_W(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata),
`ifdef RAM_ARB_STATS_EN
        .a_grants(a_grants), .b_grants(b_grants),
`endif
        .busy(busy), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    // RAM model: zeros except 0x100..0x105 = 0x30..0x35.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i] <= (i >= 'h100 && i <= 'h105) ? 8'(8'h30 + (i - 'h100)) : 8'h00;
            end
            preloaded <= 1'b1;
        end else if (!mem_wr_en) begin
            ram[mem_addr] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
    end
    assign mem_rdata = ram[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops the next expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (b_ack) nb_ack++;
        if (a_ack || b_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b with empty scoreboard", a_ack, b_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", {31'd0, b_ack}, {31'd0, e.who_b});
                chk("ack_onehot", {31'd0, a_ack & b_ack}, 0);
                chk("ack_cycle", cyc, e.cyc);
                if (e.rd) chk(e.who_b ? "b_rdata" : "a_rdata",
                              {24'd0, e.who_b ? b_rdata : a_rdata}, {24'd0, e.rdata});
            end
        end
    end

    task automatic push(input logic who_b, input logic rd, input logic [7:0] rdata, input int at);
        exp_t e;
        e.who_b = who_b; e.rd = rd; e.rdata = rdata; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic wait_acks(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 60 * n) begin
            @(negedge clk);
            budget++;
            if (a_ack || b_ack) got++;
        end
        if (got < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
        end
    endtask

    // One transaction issued in IDLE; ack expected two cycles later.
    task automatic txn(input logic who_b, input logic we, input logic [9:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd);
        @(negedge clk);
        if (who_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        push(who_b, !we, exp_rd, cyc + 2);
        wait_acks(1);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_a_ack", {31'd0, a_ack}, 0);
        chk("rst_b_ack", {31'd0, b_ack}, 0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 1);
        chk("rst_grant_b", {31'd0, grant_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int nb0;
        int w0;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset();

        // Single writer then read-back.
        txn(1'b0, 1'b1, 10'h005, 8'hA5, 8'h00);
        chk("t1_write_cycles", n_wr, 1);
        chk("t1_grant_b", {31'd0, grant_b}, 0);
        txn(1'b0, 1'b0, 10'h005, 8'h00, 8'hA5);
        chk("t1_read_no_write", n_wr, 1);

        // Simultaneous writes after reset: A first, B second.
        do_reset();
        chk_reset();
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 10'h010; a_wdata = 8'h11;
        b_req = 1; b_we = 1; b_addr = 10'h010; b_wdata = 8'h22;
        push(1'b0, 1'b0, 8'h00, cyc + 2);
        push(1'b1, 1'b0, 8'h00, cyc + 5);
        wait_acks(1);
        a_req = 0;
        wait_acks(1);
        b_req = 0;
        chk("t2_grant_b", {31'd0, grant_b}, 1);
        chk("t2_write_cycles", n_wr, 3);
        txn(1'b0, 1'b0, 10'h010, 8'h00, 8'h22);
        txn(1'b1, 1'b0, 10'h010, 8'h00, 8'h22);

        // Both hold read requests: strict alternation, 3 cycles apart.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 10'h100;
        b_req = 1; b_we = 0; b_addr = 10'h101;
        c = cyc;
        for (int i = 0; i < 6; i++) begin
            push(i[0], 1'b1, i[0] ? 8'h31 : 8'h30, c + 2 + 3 * i);
        end
        wait_acks(6);
        a_req = 0;
        b_req = 0;

        // Reset during B's write ACCESS drops the transaction.
        @(negedge clk);
        b_req = 1; b_we = 1; b_addr = 10'h3FF; b_wdata = 8'h7E;
        nb0 = nb_ack;
        w0 = n_wr;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_wr_en_suppressed", {31'd0, mem_wr_en}, 1);
        chk("t4_busy_in_access", {31'd0, busy}, 1);
        @(negedge clk);
        reset = 1'b0;
        b_req = 0;
        b_we = 0;
        repeat (6) @(negedge clk);
        chk("t4_no_b_ack", nb_ack, nb0);
        chk("t4_no_write", n_wr, w0);
        chk_reset();
        txn(1'b0, 1'b0, 10'h3FF, 8'h00, 8'h00);

        // Inputs changed during ACCESS are ignored; B's rdata is untouched by A reads.
        txn(1'b1, 1'b0, 10'h101, 8'h00, 8'h31);
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 10'h020; a_wdata = 8'h5C;
        push(1'b0, 1'b0, 8'h00, cyc + 2);
        @(negedge clk);
        a_addr = 10'h021;
        a_wdata = 8'hFF;
        wait_acks(1);
        a_req = 0;
        txn(1'b0, 1'b0, 10'h020, 8'h00, 8'h5C);
        txn(1'b0, 1'b0, 10'h021, 8'h00, 8'h00);
        chk("t5_b_rdata_kept", {24'd0, b_rdata}, 32'h31);

`ifdef RAM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            txn(1'b0, 1'b0, 10'h100, 8'h00, 8'h30);
            @(posedge clk);
            #1;
            chk("a_grants", {30'd0, a_grants}, (i < 3) ? i + 1 : 3);
            chk("b_grants", {30'd0, b_grants}, 0);
        end
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
